// File: rtl/chess_clock_ctrl_if.sv
// rtl/chess_clock_ctrl_if.sv - control/status bundle for the chess clock game controller
//
// Purpose: groups the chess clock controller's event inputs and its BCD time/status outputs.
// Signals:
//   CE          one-second tick, single-cycle pulse
//   start_btn   start/pause toggle, single-cycle pulse
//   p1_btn      player 1 ends move, single-cycle pulse
//   p2_btn      player 2 ends move, single-cycle pulse
//   new_game    reload both times and return to idle, single-cycle pulse
//   p1_time     player 1 remaining time, BCD {min_t, min_u, sec_t, sec_u}
//   p2_time     player 2 remaining time, same format
//   turn        0 = player 1 to move, 1 = player 2 to move
//   running     clock is counting
//   timeout_p1  player 1 flag fell
//   timeout_p2  player 2 flag fell
// Modports: master drives the events (board logic / bench), slave is the controller.
interface chess_clock_ctrl_if;
  logic        CE;
  logic        start_btn;
  logic        p1_btn;
  logic        p2_btn;
  logic        new_game;
  logic [15:0] p1_time;
  logic [15:0] p2_time;
  logic        turn;
  logic        running;
  logic        timeout_p1;
  logic        timeout_p2;

  modport master (
    output CE, start_btn, p1_btn, p2_btn, new_game,
    input  p1_time, p2_time, turn, running, timeout_p1, timeout_p2
  );

  modport slave (
    input  CE, start_btn, p1_btn, p2_btn, new_game,
    output p1_time, p2_time, turn, running, timeout_p1, timeout_p2
  );
endinterface

// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-player chess clock game controller with BCD mm:ss times
//
// Purpose: keeps both players' remaining time in BCD, counts down the active player on
// each one-second tick, switches turns on the mover's button with a Fischer increment,
// and handles start/pause, timeout and new-game.
// Ports:
//   CLK  system clock
//   CLR  asynchronous active-high reset
//   bus  chess_clock_ctrl_if.slave: event pulses in, BCD times and status flags out
// Parameters:
//   INIT_MIN  starting minutes per player (1..99)
//   INIT_SEC  starting seconds per player (0..59)
//   INC_SEC   increment added to the mover's time on a turn switch (0..59)
module chess_clock_ctrl #(
  parameter int INIT_MIN = 5,
  parameter int INIT_SEC = 0,
  parameter int INC_SEC  = 0
) (
  input  logic               CLK,
  input  logic               CLR,
  chess_clock_ctrl_if.slave  bus
);

  localparam logic [15:0] INIT_BCD = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                      4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_TIMEOUT} state_t;

  state_t      r_state;
  logic [15:0] r_p1_time;
  logic [15:0] r_p2_time;
  logic        r_turn;
  logic        r_running;
  logic        r_to_p1;
  logic        r_to_p2;

  // Subtract one second with a nibble borrow chain; 00:00 is held, never wrapped.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (t == 16'h0000) return 16'h0000;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Add the increment with a carry from seconds (base 60) into minutes, saturating at 99:59.
  function automatic logic [15:0] bcd_add_inc(input logic [15:0] t);
    logic [6:0] sec, min;
    sec = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(INC_SEC);
    min = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
    if (sec >= 7'd60) begin
      sec = sec - 7'd60;
      min = min + 7'd1;
    end
    if (min > 7'd99) return 16'h9959;
    return {4'(min / 7'd10), 4'(min % 7'd10), 4'(sec / 7'd10), 4'(sec % 7'd10)};
  endfunction

  logic [15:0] w_act_time;
  logic [15:0] w_dec_time;
  logic [15:0] w_inc_time;
  logic        w_press;
  logic        w_hit_zero;

  assign w_act_time = r_turn ? r_p2_time : r_p1_time;
  assign w_dec_time = bcd_dec(w_act_time);
  // A tick in the same cycle as the mover's button is applied before the increment.
  assign w_inc_time = bcd_add_inc(bus.CE ? w_dec_time : w_act_time);
  assign w_press    = r_turn ? bus.p2_btn : bus.p1_btn;
  assign w_hit_zero = bus.CE && (w_dec_time == 16'h0000);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state   <= S_IDLE;
      r_p1_time <= INIT_BCD;
      r_p2_time <= INIT_BCD;
      r_turn    <= 1'b0;
      r_running <= 1'b0;
      r_to_p1   <= 1'b0;
      r_to_p2   <= 1'b0;
    end else if (bus.new_game) begin
      r_state   <= S_IDLE;
      r_p1_time <= INIT_BCD;
      r_p2_time <= INIT_BCD;
      r_turn    <= 1'b0;
      r_running <= 1'b0;
      r_to_p1   <= 1'b0;
      r_to_p2   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_btn) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_turn    <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.start_btn) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end else if (w_hit_zero) begin
            // Flag falls: timeout beats a simultaneous move, turn is held.
            if (r_turn) begin
              r_p2_time <= w_dec_time;
              r_to_p2   <= 1'b1;
            end else begin
              r_p1_time <= w_dec_time;
              r_to_p1   <= 1'b1;
            end
            r_state   <= S_TIMEOUT;
            r_running <= 1'b0;
          end else if (w_press) begin
            if (r_turn) r_p2_time <= w_inc_time;
            else        r_p1_time <= w_inc_time;
            r_turn <= ~r_turn;
          end else if (bus.CE) begin
            if (r_turn) r_p2_time <= w_dec_time;
            else        r_p1_time <= w_dec_time;
          end
        end
        S_PAUSE: begin
          if (bus.start_btn) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_TIMEOUT: begin
          r_state <= S_TIMEOUT;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p1_time    = r_p1_time;
  assign bus.p2_time    = r_p2_time;
  assign bus.turn       = r_turn;
  assign bus.running    = r_running;
  assign bus.timeout_p1 = r_to_p1;
  assign bus.timeout_p2 = r_to_p2;

endmodule
